// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage and the main Control decoder.
// Contents: XLEN, NOP encoding, base-ISA major opcodes, fetch FSM state
// encoding and a word-alignment helper.
package instruction_fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  // Major opcodes, Instruction[6:0]
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle.
//   Imem*    : request/grant/response channel to instruction memory
//   Instr*   : valid/ready channel towards decode, plus Instruction/Opcode
//   Redirect : one-cycle branch/jump redirect strobe with target RedirectPC
// master = fetch unit, slave = memory/decode/branch environment.
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;

  logic            ImemReq;
  logic [XLEN-1:0] ImemAddr;
  logic            ImemGnt;
  logic            ImemRValid;
  logic [XLEN-1:0] ImemRData;
  logic            InstrValid;
  logic            InstrReady;
  logic [XLEN-1:0] Instruction;
  logic [6:0]      Opcode;
  logic [XLEN-1:0] InstrPC;
  logic            Redirect;
  logic [XLEN-1:0] RedirectPC;

  modport master (
    output ImemReq, ImemAddr, InstrValid, Instruction, Opcode, InstrPC,
    input  ImemGnt, ImemRValid, ImemRData, InstrReady, Redirect, RedirectPC
  );

  modport slave (
    input  ImemReq, ImemAddr, InstrValid, Instruction, Opcode, InstrPC,
    output ImemGnt, ImemRValid, ImemRData, InstrReady, Redirect, RedirectPC
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO buffering fetched words for decode.
//   clk, rst_n      : clock, asynchronous active-low reset
//   flush           : empties the FIFO; wins over push and pop
//   push, push_data : write side; push while full is taken only with a pop
//   pop, pop_data   : read side; pop while empty is ignored, pop_data is 0 when empty
//   empty, full     : status
//   count           : current occupancy
module fetch_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 64,
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic [CntW-1:0]  count
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(Depth));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage needs no reset: contents are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues one word fetch at a time to instruction
// memory, buffers returned words with their address, and presents them to
// decode. A redirect retargets the PC, flushes the buffer and discards any
// response still owed by memory.
//   Clock : sole clock, rising edge
//   Reset : asynchronous active-low reset
//   bus   : instruction_fetch_if master (memory, decode and redirect channels)
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic                 Clock,
  input logic                 Reset,
  instruction_fetch_if.master bus
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   pc_q, fetch_addr_q;
  logic              grant, push, pop;
  logic              fifo_empty, fifo_full;
  logic [CntW-1:0]   fifo_count;
  logic [CntW:0]     occ_after_push;
  logic [2*XLEN-1:0] fifo_rdata;

  assign grant = (state_q == REQ) && bus.ImemGnt;
  assign push  = (state_q == WAIT) && bus.ImemRValid && !bus.Redirect;
  assign pop   = !fifo_empty && bus.InstrReady;

  assign occ_after_push = {1'b0, fifo_count} + (CntW + 1)'(1) - (CntW + 1)'(pop);

  // State register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      // Nothing is in flight in IDLE, so free slots alone decide.
      IDLE:    if (!fifo_full) state_d = REQ;
      REQ:     if (bus.ImemGnt) state_d = WAIT;
      WAIT:    if (bus.ImemRValid) begin
        state_d = (occ_after_push < (CntW + 1)'(FIFO_DEPTH)) ? REQ : IDLE;
      end
      DROP:    if (bus.ImemRValid) state_d = REQ;
      default: state_d = IDLE;
    endcase
    if (bus.Redirect) begin
      // A response is still owed if the request is accepted now or already
      // accepted and not yet answered; it belongs to the old path.
      if (grant ||
          ((state_q == WAIT || state_q == DROP) && !bus.ImemRValid)) begin
        state_d = DROP;
      end else begin
        state_d = REQ;
      end
    end
  end

  // Outputs
  always_comb begin
    bus.ImemReq     = (state_q == REQ);
    bus.ImemAddr    = pc_q;
    bus.InstrValid  = !fifo_empty;
    bus.Instruction = fifo_rdata[2*XLEN-1:XLEN];
    bus.InstrPC     = fifo_rdata[XLEN-1:0];
    bus.Opcode      = fifo_rdata[XLEN+6:XLEN];
  end

  // PC advances on grant; the accepted address is kept to tag the response.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc_q         <= RESET_PC;
      fetch_addr_q <= RESET_PC;
    end else if (bus.Redirect) begin
      pc_q <= word_align(bus.RedirectPC);
    end else if (grant) begin
      pc_q         <= pc_q + 32'd4;
      fetch_addr_q <= pc_q;
    end
  end

  fetch_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (2 * XLEN)
  ) u_fifo (
    .clk       (Clock),
    .rst_n     (Reset),
    .flush     (bus.Redirect),
    .push      (push),
    .push_data ({bus.ImemRData, fetch_addr_q}),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  localparam logic [31:0] I0  = {25'h0000101, OPC_OP_IMM};
  localparam logic [31:0] I1  = {25'h0000202, OPC_LOAD};
  localparam logic [31:0] I2  = {25'h0000303, OPC_STORE};
  localparam logic [31:0] I3  = {25'h0000404, OPC_BRANCH};
  localparam logic [31:0] I4  = {25'h0000505, OPC_JAL};
  localparam logic [31:0] I5  = {25'h0000606, OPC_R};
  localparam logic [31:0] I6  = {25'h0000707, OPC_JALR};
  localparam logic [31:0] I7  = {25'h0000808, OPC_R};
  localparam logic [31:0] I8  = {25'h0000909, OPC_LOAD};
  localparam logic [31:0] I10 = {25'h0000A0A, OPC_STORE};
  localparam logic [31:0] I11 = {25'h0000B0B, OPC_OP_IMM};
  localparam logic [31:0] I12 = {25'h0000C0C, OPC_JAL};
  localparam logic [31:0] I13 = {25'h0000D0D, OPC_LOAD};
  localparam logic [31:0] I14 = {25'h0000E0E, OPC_BRANCH};

  instruction_fetch_if bus ();

  instruction_fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   {31'd0, bus.ImemReq}, 32'd0);
    chk({tag, "_addr"},  bus.ImemAddr, 32'h0);
    chk({tag, "_valid"}, {31'd0, bus.InstrValid}, 32'd0);
    chk({tag, "_instr"}, bus.Instruction, 32'h0);
    chk({tag, "_opc"},   {25'd0, bus.Opcode}, 32'h0);
    chk({tag, "_pc"},    bus.InstrPC, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus.ImemGnt = 1'b1;
    bus.ImemRValid = 1'b0;
    bus.ImemRData = '0;
    bus.InstrReady = 1'b0;
    bus.Redirect = 1'b0;
    bus.RedirectPC = '0;

    // Reset state
    tick(); tick();
    chk_reset("rst");
    rst_n = 1'b1;
    chk("rel_no_req", {31'd0, bus.ImemReq}, 32'd0);
    tick();
    chk("rel_req", {31'd0, bus.ImemReq}, 32'd1);
    chk("rel_addr", bus.ImemAddr, 32'h0);

    // Streaming fetch 0,4,8
    bus.InstrReady = 1'b1;
    tick();
    chk("a_wait_no_req", {31'd0, bus.ImemReq}, 32'd0);
    bus.ImemRValid = 1'b1; bus.ImemRData = I0;
    tick(); bus.ImemRValid = 1'b0;
    chk("a_valid0", {31'd0, bus.InstrValid}, 32'd1);
    chk("a_pc0", bus.InstrPC, 32'h0);
    chk("a_instr0", bus.Instruction, I0);
    chk("a_opc0", {25'd0, bus.Opcode}, {25'd0, OPC_OP_IMM});
    chk("a_addr4", bus.ImemAddr, 32'h4);
    tick();
    chk("a_popped", {31'd0, bus.InstrValid}, 32'd0);
    bus.ImemRValid = 1'b1; bus.ImemRData = I1;
    tick(); bus.ImemRValid = 1'b0;
    chk("a_pc1", bus.InstrPC, 32'h4);
    chk("a_instr1", bus.Instruction, I1);
    chk("a_addr8", bus.ImemAddr, 32'h8);
    tick();
    bus.ImemRValid = 1'b1; bus.ImemRData = I2;
    tick(); bus.ImemRValid = 1'b0;
    chk("a_pc2", bus.InstrPC, 32'h8);
    chk("a_opc2", {25'd0, bus.Opcode}, {25'd0, OPC_STORE});
    chk("a_addr12", bus.ImemAddr, 32'hC);

    // Back-pressure: exactly two fetches then stall
    bus.ImemGnt = 1'b0;
    tick();
    chk("b_empty", {31'd0, bus.InstrValid}, 32'd0);
    chk("b_addr_hold", bus.ImemAddr, 32'hC);
    bus.InstrReady = 1'b0; bus.ImemGnt = 1'b1;
    tick();
    bus.ImemRValid = 1'b1; bus.ImemRData = I3;
    tick(); bus.ImemRValid = 1'b0;
    chk("b_req2", {31'd0, bus.ImemReq}, 32'd1);
    chk("b_addr16", bus.ImemAddr, 32'h10);
    tick();
    bus.ImemRValid = 1'b1; bus.ImemRData = I4;
    tick(); bus.ImemRValid = 1'b0;
    chk("b_full_no_req", {31'd0, bus.ImemReq}, 32'd0);
    tick(); tick();
    chk("b_still_idle", {31'd0, bus.ImemReq}, 32'd0);
    chk("b_hold_pc", bus.InstrPC, 32'hC);
    chk("b_hold_instr", bus.Instruction, I3);
    bus.InstrReady = 1'b1;
    tick();
    chk("b_pc16", bus.InstrPC, 32'h10);
    chk("b_instr4", bus.Instruction, I4);
    chk("b_idle_req", {31'd0, bus.ImemReq}, 32'd0);
    tick();
    chk("b_resume_req", {31'd0, bus.ImemReq}, 32'd1);
    chk("b_resume_addr", bus.ImemAddr, 32'h14);
    chk("b_resume_empty", {31'd0, bus.InstrValid}, 32'd0);

    // Redirect while waiting for data: response dropped
    tick();
    bus.Redirect = 1'b1; bus.RedirectPC = 32'h100;
    tick(); bus.Redirect = 1'b0;
    chk("c_drop_no_req", {31'd0, bus.ImemReq}, 32'd0);
    tick();
    chk("c_drop_hold", {31'd0, bus.ImemReq}, 32'd0);
    bus.ImemRValid = 1'b1; bus.ImemRData = I5;
    tick(); bus.ImemRValid = 1'b0;
    chk("c_discarded", {31'd0, bus.InstrValid}, 32'd0);
    chk("c_addr", bus.ImemAddr, 32'h100);
    chk("c_req", {31'd0, bus.ImemReq}, 32'd1);
    tick();
    bus.ImemRValid = 1'b1; bus.ImemRData = I6;
    tick(); bus.ImemRValid = 1'b0;
    chk("c_pc", bus.InstrPC, 32'h100);
    chk("c_instr", bus.Instruction, I6);
    chk("c_addr_next", bus.ImemAddr, 32'h104);

    // Redirect in REQ without grant: unaligned target, flush, no drop
    bus.InstrReady = 1'b0; bus.ImemGnt = 1'b0;
    bus.Redirect = 1'b1; bus.RedirectPC = 32'h203;
    tick(); bus.Redirect = 1'b0;
    chk("d_addr", bus.ImemAddr, 32'h200);
    chk("d_req", {31'd0, bus.ImemReq}, 32'd1);
    chk("d_flush", {31'd0, bus.InstrValid}, 32'd0);
    bus.InstrReady = 1'b1; bus.ImemGnt = 1'b1;
    tick();
    bus.ImemRValid = 1'b1; bus.ImemRData = I7;
    tick(); bus.ImemRValid = 1'b0;
    chk("d_pc", bus.InstrPC, 32'h200);
    chk("d_instr", bus.Instruction, I7);
    chk("d_addr_next", bus.ImemAddr, 32'h204);

    // Redirect coincident with grant: drop, then wrap at top of address space
    bus.InstrReady = 1'b0;
    bus.Redirect = 1'b1; bus.RedirectPC = 32'hFFFF_FFFC;
    tick(); bus.Redirect = 1'b0;
    chk("e_flush", {31'd0, bus.InstrValid}, 32'd0);
    chk("e_drop_no_req", {31'd0, bus.ImemReq}, 32'd0);
    bus.InstrReady = 1'b1;
    bus.ImemRValid = 1'b1; bus.ImemRData = I8;
    tick(); bus.ImemRValid = 1'b0;
    chk("e_discarded", {31'd0, bus.InstrValid}, 32'd0);
    chk("e_addr", bus.ImemAddr, 32'hFFFF_FFFC);
    tick();
    bus.ImemRValid = 1'b1; bus.ImemRData = NOP;
    tick(); bus.ImemRValid = 1'b0;
    chk("e_pc", bus.InstrPC, 32'hFFFF_FFFC);
    chk("e_instr", bus.Instruction, NOP);
    chk("e_wrap", bus.ImemAddr, 32'h0);

    // Redirect coincident with response: discarded, straight to REQ
    tick();
    bus.ImemRValid = 1'b1; bus.ImemRData = I10;
    bus.Redirect = 1'b1; bus.RedirectPC = 32'h40;
    tick(); bus.ImemRValid = 1'b0; bus.Redirect = 1'b0;
    chk("f_req", {31'd0, bus.ImemReq}, 32'd1);
    chk("f_addr", bus.ImemAddr, 32'h40);
    chk("f_valid", {31'd0, bus.InstrValid}, 32'd0);
    tick();
    bus.ImemRValid = 1'b1; bus.ImemRData = I11;
    tick(); bus.ImemRValid = 1'b0;
    chk("f_pc", bus.InstrPC, 32'h40);
    chk("f_instr", bus.Instruction, I11);

    // Response strobe outside WAIT/DROP is ignored
    bus.ImemGnt = 1'b0;
    bus.ImemRValid = 1'b1; bus.ImemRData = I12;
    tick(); bus.ImemRValid = 1'b0;
    chk("g_ignored", {31'd0, bus.InstrValid}, 32'd0);
    chk("g_addr", bus.ImemAddr, 32'h44);

    // Reset during WAIT with a buffered word, stale response after release
    bus.InstrReady = 1'b0; bus.ImemGnt = 1'b1;
    tick();
    bus.ImemRValid = 1'b1; bus.ImemRData = I13;
    tick(); bus.ImemRValid = 1'b0;
    tick();
    chk("h_pre_valid", {31'd0, bus.InstrValid}, 32'd1);
    chk("h_pre_instr", bus.Instruction, I13);
    rst_n = 1'b0;
    #2;
    chk_reset("h_rst");
    bus.ImemRValid = 1'b1; bus.ImemRData = I14;
    tick();
    rst_n = 1'b1;
    chk("h_rel_no_req", {31'd0, bus.ImemReq}, 32'd0);
    tick(); bus.ImemRValid = 1'b0;
    chk("h_stale_dropped", {31'd0, bus.InstrValid}, 32'd0);
    chk("h_req", {31'd0, bus.ImemReq}, 32'd1);
    chk("h_addr", bus.ImemAddr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
